// File: rtl/dmc_ctrl.sv
// Controller for a direct-mapped, write-back, write-allocate cache with one-word lines.
// Owns the tag/valid/dirty state and sequences lookup, writeback and fill over a req/ack port.
module dmc_ctrl #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int INDEX_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic               cpu_rd,
  input  logic               cpu_wr,
  input  logic [DATA_W-1:0]  cpu_din,
  output logic [DATA_W-1:0]  cpu_dout,
  output logic               cpu_ready,
  output logic               cache_hit,
  output logic               busy,
  output logic [INDEX_W-1:0] dary_addr,
  output logic               dary_we,
  output logic [DATA_W-1:0]  dary_wdata,
  input  logic [DATA_W-1:0]  dary_rdata,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic [DATA_W-1:0]  mem_dout,
  input  logic [DATA_W-1:0]  mem_din,
  input  logic               mem_ack,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt
);
  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, DONE} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  din_q;
  logic               wr_q;
  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;
  logic [TAG_W-1:0]   tag_mem [LINES];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic               line_dirty;
  logic               lookup_hit;
  logic               install;

  assign idx = addr_q[INDEX_W-1:0];
  assign tag = addr_q[ADDR_W-1:INDEX_W];

  // The data array reads synchronously, so the incoming index is presented while still idle.
  assign dary_addr = (state == IDLE) ? cpu_addr[INDEX_W-1:0] : idx;

  // NOTE: every always_comb output is assigned a default first, so no path can infer a latch.
  always_comb begin
    hit        = valid_q[idx] && (tag_mem[idx] == tag);
    line_dirty = valid_q[idx] && dirty_q[idx];
    lookup_hit = (state == LOOKUP) && hit;
    install    = 1'b0;
    case (state)
      LOOKUP:  install = !hit && !line_dirty && wr_q;
      WB:      install = mem_ack && wr_q;
      FILL:    install = mem_ack;
      default: install = 1'b0;
    endcase
  end

  // NOTE: the tag array is deliberately not reset; valid_q qualifies every tag compare.
  always_ff @(posedge clk) begin
    if (install) tag_mem[idx] <= tag;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= IDLE;
      addr_q     <= '0;
      din_q      <= '0;
      wr_q       <= 1'b0;
      valid_q    <= '0;
      dirty_q    <= '0;
      cpu_dout   <= '0;
      cpu_ready  <= 1'b0;
      cache_hit  <= 1'b0;
      busy       <= 1'b0;
      dary_we    <= 1'b0;
      dary_wdata <= '0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_dout   <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      cpu_ready <= 1'b0;
      dary_we   <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_rd || cpu_wr) begin
            addr_q <= cpu_addr;
            din_q  <= cpu_din;
            wr_q   <= !cpu_rd;
            busy   <= 1'b1;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            cache_hit <= 1'b1;
            if (wr_q) begin
              dary_we      <= 1'b1;
              dary_wdata   <= din_q;
              dirty_q[idx] <= 1'b1;
            end else begin
              cpu_dout <= dary_rdata;
            end
          end else if (line_dirty) begin
            mem_addr <= {tag_mem[idx], idx};
            mem_dout <= dary_rdata;
            mem_wr   <= 1'b1;
            state    <= WB;
          end else if (!wr_q) begin
            mem_addr <= addr_q;
            mem_rd   <= 1'b1;
            state    <= FILL;
          end
        end
        WB: begin
          if (mem_ack) begin
            mem_wr <= 1'b0;
            if (!wr_q) begin
              mem_addr <= addr_q;
              mem_rd   <= 1'b1;
              state    <= FILL;
            end
          end
        end
        FILL: begin
          if (mem_ack) mem_rd <= 1'b0;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Every miss finishes by installing the new line; a write miss needs no fill.
      if (install) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= wr_q;
        dary_we      <= 1'b1;
        dary_wdata   <= wr_q ? din_q : mem_din;
        cache_hit    <= 1'b0;
        if (!wr_q) cpu_dout <= mem_din;
      end

      if (lookup_hit || install) begin
        state     <= DONE;
        cpu_ready <= 1'b1;
      end

      if (lookup_hit && hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
      if (install && miss_cnt != '1)   miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_dmc_ctrl.sv
// Self-checking bench for dmc_ctrl: a cache-level model predicts hits, memory traffic,
// data and latency; a single compare process checks the DUT every cycle against it.
module tb_dmc_ctrl;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 16;
  localparam int INDEX_W = 8;
  // Counters are built narrow here so that saturation is reachable in a short run.
  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk;
  logic               clr;
  logic [ADDR_W-1:0]  cpu_addr;
  logic               cpu_rd;
  logic               cpu_wr;
  logic [DATA_W-1:0]  cpu_din;
  logic [DATA_W-1:0]  cpu_dout;
  logic               cpu_ready;
  logic               cache_hit;
  logic               busy;
  logic [INDEX_W-1:0] dary_addr;
  logic               dary_we;
  logic [DATA_W-1:0]  dary_wdata;
  logic [DATA_W-1:0]  dary_rdata;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_rd;
  logic               mem_wr;
  logic [DATA_W-1:0]  mem_dout;
  logic [DATA_W-1:0]  mem_din = '0;
  logic               mem_ack = 1'b0;
  logic [CNT_W-1:0]   hit_cnt;
  logic [CNT_W-1:0]   miss_cnt;

  dmc_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INDEX_W(INDEX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ready(cpu_ready), .cache_hit(cache_hit), .busy(busy),
    .dary_addr(dary_addr), .dary_we(dary_we), .dary_wdata(dary_wdata), .dary_rdata(dary_rdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Environment: synchronous data-array RAM and a main memory with programmable ack delay.
  logic [DATA_W-1:0] dary    [256];
  logic [DATA_W-1:0] ext_mem [4096];

  always @(posedge clk) begin
    if (dary_we) dary[dary_addr] <= dary_wdata;
    dary_rdata <= dary[dary_addr];
  end

  int                ack_wait = 2;
  int                wait_cnt = 0;
  bit                mem_auto = 1'b1;
  bit                force_ack = 1'b0;
  int                rd_acks = 0;
  int                wr_acks = 0;
  logic [ADDR_W-1:0] last_wr_addr = '0;
  logic [DATA_W-1:0] last_wr_data = '0;

  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (force_ack) begin
      mem_ack = 1'b1;
      mem_din = 16'hDEAD;
    end else if (mem_auto && clr && (mem_rd || mem_wr)) begin
      if (wait_cnt >= ack_wait) begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
        if (mem_wr) begin
          ext_mem[mem_addr] = mem_dout;
          last_wr_addr      = mem_addr;
          last_wr_data      = mem_dout;
          wr_acks++;
        end else begin
          mem_din = ext_mem[mem_addr];
          rd_acks++;
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Cache-level reference model.
  bit                m_valid [256];
  bit                m_dirty [256];
  logic [3:0]        m_tag   [256];
  logic [DATA_W-1:0] m_data  [256];
  logic [DATA_W-1:0] m_mem   [4096];
  int                m_hits;
  int                m_misses;

  bit                exp_pending = 1'b0;
  bit                exp_rd, exp_hit, exp_wb, exp_fill;
  logic [DATA_W-1:0] exp_dout, exp_wb_data;
  logic [ADDR_W-1:0] exp_wb_addr, exp_fill_addr;
  int                exp_lat;
  int                req_edge;
  int                cyc = 0;
  bit                chk_on = 1'b0;
  bit                wb_seen = 1'b0;

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    return {a, 4'h5} ^ 16'h3C3C;
  endfunction

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ext_mem[a] = d;
    m_mem[a]   = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic model_expect(input logic [ADDR_W-1:0] addr, input bit rd, input logic [DATA_W-1:0] din);
    int unsigned i;
    logic [3:0]  tg;
    i        = 32'(addr[7:0]);
    tg       = addr[11:8];
    exp_rd   = rd;
    exp_wb   = 1'b0;
    exp_fill = 1'b0;
    if (m_valid[i] && m_tag[i] == tg) begin
      exp_hit = 1'b1;
      if (rd) exp_dout = m_data[i];
      else begin
        m_data[i]  = din;
        m_dirty[i] = 1'b1;
      end
      if (m_hits < CNT_MAX) m_hits++;
    end else begin
      exp_hit = 1'b0;
      if (m_valid[i] && m_dirty[i]) begin
        exp_wb             = 1'b1;
        exp_wb_addr        = {m_tag[i], addr[7:0]};
        exp_wb_data        = m_data[i];
        m_mem[exp_wb_addr] = m_data[i];
      end
      if (rd) begin
        exp_fill      = 1'b1;
        exp_fill_addr = addr;
        m_data[i]     = m_mem[addr];
        exp_dout      = m_data[i];
        m_dirty[i]    = 1'b0;
      end else begin
        m_data[i]  = din;
        m_dirty[i] = 1'b1;
      end
      m_valid[i] = 1'b1;
      m_tag[i]   = tg;
      if (m_misses < CNT_MAX) m_misses++;
    end
    exp_lat     = 2 + (exp_wb ? ack_wait + 1 : 0) + (exp_fill ? ack_wait + 1 : 0);
    exp_pending = 1'b1;
  endtask

  // Compare process: sampled 1 time unit after every rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (chk_on && clr) begin
      check("mem_rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
      if (mem_rd || mem_wr) check("busy_during_mem", 32'(busy), 32'd1);
      if (mem_wr) begin
        check("unexpected_mem_wr", 32'(mem_wr), 32'(exp_wb));
        check("wb_addr", 32'(mem_addr), 32'(exp_wb_addr));
        check("wb_data", 32'(mem_dout), 32'(exp_wb_data));
        wb_seen = 1'b1;
      end
      if (mem_rd) begin
        check("unexpected_mem_rd", 32'(mem_rd), 32'(exp_fill));
        check("fill_addr", 32'(mem_addr), 32'(exp_fill_addr));
        check("wb_before_fill", 32'(wb_seen), 32'(exp_wb));
      end
      if (cpu_ready) begin
        check("unexpected_ready", 32'(cpu_ready), 32'(exp_pending));
        if (exp_pending) begin
          check("latency", 32'(cyc - req_edge + 1), 32'(exp_lat));
          check("cache_hit", 32'(cache_hit), 32'(exp_hit));
          if (exp_rd) check("cpu_dout", 32'(cpu_dout), 32'(exp_dout));
          check("hit_cnt", 32'(hit_cnt), 32'(m_hits));
          check("miss_cnt", 32'(miss_cnt), 32'(m_misses));
          check("busy_in_done", 32'(busy), 32'd1);
          check("wb_happened", 32'(wb_seen), 32'(exp_wb));
          exp_pending = 1'b0;
          exp_wb      = 1'b0;
          exp_fill    = 1'b0;
          wb_seen     = 1'b0;
        end
      end
    end
  end

  task automatic access(input logic [ADDR_W-1:0] addr, input logic rd, input logic wr,
                        input logic [DATA_W-1:0] din,
                        output logic [DATA_W-1:0] dout, output logic hit, output int lat);
    @(negedge clk);
    model_expect(addr, rd, din);
    req_edge = cyc + 1;
    cpu_addr = addr;
    cpu_rd   = rd;
    cpu_wr   = wr;
    cpu_din  = din;
    lat      = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cpu_ready && lat < 200);
    if (!cpu_ready) check("ready_timeout", 32'(cpu_ready), 32'd1);
    dout   = cpu_dout;
    hit    = cache_hit;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  logic [DATA_W-1:0] d;
  logic              h;
  int                lat;
  int                rd0;
  int                wr0;

  initial begin
    clr      = 1'b0;
    cpu_addr = '0;
    cpu_rd   = 1'b0;
    cpu_wr   = 1'b0;
    cpu_din  = '0;
    for (int i = 0; i < 256; i++) dary[i] = '0;
    for (int a = 0; a < 4096; a++) preload(12'(a), pattern(12'(a)));
    preload(12'h123, 16'hBEEF);
    preload(12'h523, 16'h2222);
    preload(12'h010, 16'h0A0A);
    model_reset();

    repeat (3) @(negedge clk);
    check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check("rst_cache_hit", 32'(cache_hit), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_dary_we", 32'(dary_we), 32'd0);
    check("rst_cpu_dout", 32'(cpu_dout), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_dout", 32'(mem_dout), 32'd0);
    check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    check("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    clr    = 1'b1;
    chk_on = 1'b1;

    // Clean read miss, then a hit on the same line.
    rd0 = rd_acks;
    access(12'h123, 1'b1, 1'b0, 16'h0, d, h, lat);
    check("miss_0x123_dout", 32'(d), 32'hBEEF);
    check("miss_0x123_hit", 32'(h), 32'd0);
    check("miss_0x123_miss_cnt", 32'(miss_cnt), 32'd1);
    check("miss_0x123_fills", 32'(rd_acks - rd0), 32'd1);
    rd0 = rd_acks;
    wr0 = wr_acks;
    access(12'h123, 1'b1, 1'b0, 16'h0, d, h, lat);
    check("hit_0x123_dout", 32'(d), 32'hBEEF);
    check("hit_0x123_hit", 32'(h), 32'd1);
    check("hit_0x123_latency", 32'(lat), 32'd2);
    check("hit_0x123_hit_cnt", 32'(hit_cnt), 32'd1);
    check("hit_0x123_no_traffic", 32'((rd_acks - rd0) + (wr_acks - wr0)), 32'd0);

    // Write hit dirties the line; a conflicting read must write it back first.
    access(12'h123, 1'b0, 1'b1, 16'h1111, d, h, lat);
    check("wr_hit_0x123_hit", 32'(h), 32'd1);
    access(12'h523, 1'b1, 1'b0, 16'h0, d, h, lat);
    check("wb_0x123_addr", 32'(last_wr_addr), 32'h123);
    check("wb_0x123_data", 32'(last_wr_data), 32'h1111);
    check("fill_0x523_dout", 32'(d), 32'h2222);
    check("fill_0x523_hit", 32'(h), 32'd0);
    wr0 = wr_acks;
    access(12'h923, 1'b1, 1'b0, 16'h0, d, h, lat);
    check("clean_line_no_wb", 32'(wr_acks - wr0), 32'd0);

    // Write miss on an invalid line allocates without memory traffic.
    rd0 = rd_acks;
    wr0 = wr_acks;
    access(12'h0FF, 1'b0, 1'b1, 16'hAAAA, d, h, lat);
    check("wr_miss_0x0ff_hit", 32'(h), 32'd0);
    check("wr_miss_0x0ff_no_traffic", 32'((rd_acks - rd0) + (wr_acks - wr0)), 32'd0);
    access(12'h0FF, 1'b1, 1'b0, 16'h0, d, h, lat);
    check("rd_0x0ff_hit", 32'(h), 32'd1);
    check("rd_0x0ff_dout", 32'(d), 32'hAAAA);
    access(12'h1FF, 1'b1, 1'b0, 16'h0, d, h, lat);
    check("wb_0x0ff_addr", 32'(last_wr_addr), 32'h0FF);
    check("wb_0x0ff_data", 32'(last_wr_data), 32'hAAAA);

    // Write miss on a dirty line: writeback, then install without a fill.
    access(12'h123, 1'b0, 1'b1, 16'h3333, d, h, lat);
    rd0 = rd_acks;
    access(12'h523, 1'b0, 1'b1, 16'h4444, d, h, lat);
    check("wr_miss_dirty_wb_data", 32'(last_wr_data), 32'h3333);
    check("wr_miss_dirty_no_fill", 32'(rd_acks - rd0), 32'd0);
    check("wr_miss_dirty_latency", 32'(lat), 32'd5);

    // Reset in the middle of a fill; a late ack afterwards must be ignored.
    chk_on   = 1'b0;
    mem_auto = 1'b0;
    @(negedge clk);
    cpu_addr = 12'h777;
    cpu_rd   = 1'b1;
    lat      = 0;
    while (!mem_rd && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("pre_reset_mem_rd", 32'(mem_rd), 32'd1);
    check("pre_reset_mem_addr", 32'(mem_addr), 32'h777);
    clr    = 1'b0;
    cpu_rd = 1'b0;
    #1;
    check("mid_reset_mem_rd", 32'(mem_rd), 32'd0);
    check("mid_reset_busy", 32'(busy), 32'd0);
    check("mid_reset_miss_cnt", 32'(miss_cnt), 32'd0);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 force_ack = 1'b1;
    @(posedge clk);
    #1 force_ack = 1'b0;
    check("late_ack_busy", 32'(busy), 32'd0);
    check("late_ack_ready", 32'(cpu_ready), 32'd0);
    check("late_ack_dary_we", 32'(dary_we), 32'd0);
    @(posedge clk);
    #1;
    check("late_ack_idle_busy", 32'(busy), 32'd0);
    check("late_ack_idle_mem_rd", 32'(mem_rd), 32'd0);
    model_reset();
    mem_auto = 1'b1;
    chk_on   = 1'b1;
    access(12'h123, 1'b1, 1'b0, 16'h0, d, h, lat);
    check("post_reset_0x123_hit", 32'(h), 32'd0);
    check("post_reset_0x123_dout", 32'(d), 32'h3333);

    // Simultaneous read and write requests behave as a read.
    access(12'h010, 1'b1, 1'b1, 16'h5555, d, h, lat);
    check("rdwr_0x010_dout", 32'(d), 32'h0A0A);
    access(12'h010, 1'b1, 1'b0, 16'h0, d, h, lat);
    check("rdwr_0x010_reread", 32'(d), 32'h0A0A);
    check("rdwr_0x010_reread_hit", 32'(h), 32'd1);

    // Fill latency with zero and five wait states.
    ack_wait = 0;
    access(12'h777, 1'b1, 1'b0, 16'h0, d, h, lat);
    check("fill_w0_latency", 32'(lat), 32'd3);
    ack_wait = 5;
    access(12'h877, 1'b1, 1'b0, 16'h0, d, h, lat);
    check("fill_w5_latency", 32'(lat), 32'd8);
    check("fill_w5_dout", 32'(d), 32'(pattern(12'h877)));

    // Hit counter saturation.
    ack_wait = 1;
    for (int k = 0; k < CNT_MAX + 8; k++) access(12'h010, 1'b1, 1'b0, 16'h0, d, h, lat);
    check("hit_cnt_saturated", 32'(hit_cnt), 32'(CNT_MAX));

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
